// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer between the ICU and decode: a circular queue of 32-bit
// instructions with their PCs, fetch-ahead credit tracking, and flush-time drop of in-flight beats.
module cpu7_ifu_ibuf #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ifu_icu_ack_ic1,
    input  logic [32*FETCH_W-1:0]     icu_ifu_data_ic2,
    input  logic                      icu_ifu_data_valid_ic2,
    input  logic [31:0]               fetch_pc_ic2,
    input  logic                      flush_iq,
    input  logic                      exu_ifu_stall_req,
    output logic [31:0]               inst_f,
    output logic [31:0]               pc_f,
    output logic                      inst_valid_f,
    output logic                      iq_not_empty,
    output logic [$clog2(DEPTH):0]    iq_count,
    output logic                      fetch_ahead,
    output logic                      ibuf_ovf_err
);

    localparam int LOG_D = $clog2(DEPTH);
    localparam int LOG_F = $clog2(FETCH_W);
    localparam int OW    = $clog2(MAX_OUT) + 1;
    localparam int CW    = LOG_D + 1;
    localparam int AW    = CW + OW + 4;

    logic [LOG_D-1:0] r_head;
    logic [LOG_D-1:0] r_tail;
    logic [CW-1:0]    r_count;
    logic [OW-1:0]    r_out;
    logic [OW-1:0]    r_drop;
    logic             r_ovf;
    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];

    logic [LOG_F:0]   w_off;
    logic [LOG_F:0]   w_n;
    logic             w_deq;
    logic             w_beat_live;
    logic             w_ovf_hit;
    logic             w_enq;
    logic [AW-1:0]    w_free;
    logic [AW-1:0]    w_need;
    logic [OW-1:0]    w_out_nxt;
    logic             w_wen  [FETCH_W];
    logic [LOG_D-1:0] w_widx [FETCH_W];
    logic [31:0]      w_wpc  [FETCH_W];

    if (FETCH_W == 1) begin : g_off_single
        assign w_off = 1'b0;
    end else begin : g_off_multi
        assign w_off = {1'b0, fetch_pc_ic2[LOG_F+1:2]};
    end

    assign w_n = (LOG_F+1)'(FETCH_W) - w_off;

    assign iq_count     = r_count;
    assign iq_not_empty = (r_count != '0);
    assign inst_valid_f = iq_not_empty & ~exu_ifu_stall_req & ~flush_iq;
    assign inst_f       = r_inst[r_head];
    assign pc_f         = r_pc[r_head];
    assign ibuf_ovf_err = r_ovf;
    assign w_deq        = inst_valid_f;

    // Beats still owed to a flushed fetch stream never reach the queue.
    assign w_beat_live = icu_ifu_data_valid_ic2 & ~flush_iq & (r_drop == '0);
    assign w_free      = AW'(DEPTH) - AW'(r_count) + AW'(w_deq);
    assign w_ovf_hit   = w_beat_live & (AW'(w_n) > w_free);
    assign w_enq       = w_beat_live & ~w_ovf_hit;

    // Space must cover the queue plus every beat already requested.
    assign w_need      = AW'(r_count) + AW'(FETCH_W) * AW'(r_out) + AW'(FETCH_W);
    assign fetch_ahead = (w_need <= AW'(DEPTH)) && (r_out < OW'(MAX_OUT));

    always_comb begin
        w_out_nxt = r_out;
        if (ifu_icu_ack_ic1 && !icu_ifu_data_valid_ic2) begin
            if (r_out != OW'(MAX_OUT)) w_out_nxt = r_out + 1'b1;
        end else if (!ifu_icu_ack_ic1 && icu_ifu_data_valid_ic2) begin
            if (r_out != '0) w_out_nxt = r_out - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_wen[i]  = w_enq && (i >= int'(w_off));
            w_widx[i] = r_tail + LOG_D'(i) - LOG_D'(w_off);
            w_wpc[i]  = (fetch_pc_ic2 & ~32'(FETCH_W*4-1)) | 32'(i*4);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (w_wen[i]) begin
                r_inst[w_widx[i]] <= icu_ifu_data_ic2[32*i +: 32];
                r_pc[w_widx[i]]   <= w_wpc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_ovf <= r_ovf | w_ovf_hit;
            if (flush_iq) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_drop  <= w_out_nxt;
            end else begin
                if (w_deq) r_head <= r_head + 1'b1;
                if (w_enq) r_tail <= r_tail + LOG_D'(w_n);
                r_count <= r_count + (w_enq ? CW'(w_n) : CW'(0)) - CW'(w_deq);
                if (icu_ifu_data_valid_ic2 && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_cpu7_ifu_ibuf;

    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ack;
    logic [63:0] data;
    logic        dvalid;
    logic [31:0] fpc;
    logic        flush;
    logic        stall;
    logic [31:0] inst_f;
    logic [31:0] pc_f;
    logic        inst_valid_f;
    logic        iq_not_empty;
    logic [3:0]  iq_count;
    logic        fetch_ahead;
    logic        ibuf_ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];
    int          m_out;
    int          m_drop;
    bit          m_ovf;

    cpu7_ifu_ibuf #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .MAX_OUT(MAX_OUT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ifu_icu_ack_ic1        (ack),
        .icu_ifu_data_ic2       (data),
        .icu_ifu_data_valid_ic2 (dvalid),
        .fetch_pc_ic2           (fpc),
        .flush_iq               (flush),
        .exu_ifu_stall_req      (stall),
        .inst_f                 (inst_f),
        .pc_f                   (pc_f),
        .inst_valid_f           (inst_valid_f),
        .iq_not_empty           (iq_not_empty),
        .iq_count               (iq_count),
        .fetch_ahead            (fetch_ahead),
        .ibuf_ovf_err           (ibuf_ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fa();
        return ((DEPTH - mq.size() - FETCH_W * m_out) >= FETCH_W) && (m_out < MAX_OUT);
    endfunction

    task automatic check_all();
        bit ne;
        ne = (mq.size() != 0);
        chk("iq_count", 32'(iq_count), 32'(mq.size()));
        chk("iq_not_empty", 32'(iq_not_empty), 32'(ne));
        chk("inst_valid_f", 32'(inst_valid_f), 32'(ne && !stall && !flush));
        chk("fetch_ahead", 32'(fetch_ahead), 32'(model_fa()));
        chk("ibuf_ovf_err", 32'(ibuf_ovf_err), 32'(m_ovf));
        if (ne) begin
            chk("inst_f", inst_f, mq[0][31:0]);
            chk("pc_f", pc_f, mq[0][63:32]);
        end
    endtask

    // Applies the rules directly: pop, then either drop or push the beat's live slots.
    task automatic model_step();
        int  sz;
        int  off;
        int  n;
        bit  deq;
        int  nout;
        sz   = mq.size();
        deq  = (sz != 0) && !stall && !flush;
        nout = m_out + (ack ? 1 : 0) - (dvalid ? 1 : 0);
        if (nout > MAX_OUT) nout = MAX_OUT;
        if (nout < 0) nout = 0;
        if (flush) begin
            mq.delete();
            m_drop = nout;
        end else begin
            if (deq) void'(mq.pop_front());
            if (dvalid && m_drop > 0) begin
                m_drop--;
            end else if (dvalid) begin
                off = (fpc >> 2) % FETCH_W;
                n   = FETCH_W - off;
                if (n > DEPTH - sz + (deq ? 1 : 0)) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int s = off; s < FETCH_W; s++)
                        mq.push_back({(fpc / (FETCH_W * 4)) * (FETCH_W * 4) + 32'(s * 4),
                                      data[32*s +: 32]});
                end
            end
        end
        m_out = nout;
    endtask

    task automatic cyc(input bit a, input bit v, input logic [63:0] d, input logic [31:0] p,
                       input bit f, input bit s);
        ack = a; dvalid = v; data = d; fpc = p; flush = f; stall = s;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_drop = 0; m_ovf = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ack = 0; dvalid = 0; data = '0; fpc = '0; flush = 0; stall = 0;
        model_reset();
        #1;
        chk("rst_count", 32'(iq_count), 32'd0);
        chk("rst_valid", 32'(inst_valid_f), 32'd0);
        chk("rst_ne", 32'(iq_not_empty), 32'd0);
        chk("rst_fa", 32'(fetch_ahead), 32'd1);
        chk("rst_ovf", 32'(ibuf_ovf_err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Aligned beat
        cyc(1, 0, 64'h0, 32'h0, 0, 0);
        cyc(0, 1, {32'h00000002, 32'h00000001}, 32'h1c000000, 0, 0);
        chk("al_inst0", inst_f, 32'h00000001);
        chk("al_pc0", pc_f, 32'h1c000000);
        chk("al_cnt0", 32'(iq_count), 32'd2);
        cyc(0, 0, 64'h0, 32'h0, 0, 0);
        chk("al_inst1", inst_f, 32'h00000002);
        chk("al_pc1", pc_f, 32'h1c000004);
        chk("al_cnt1", 32'(iq_count), 32'd1);
        cyc(0, 0, 64'h0, 32'h0, 0, 0);
        chk("al_cnt2", 32'(iq_count), 32'd0);

        // Misaligned beat
        cyc(1, 0, 64'h0, 32'h0, 0, 0);
        cyc(0, 1, {32'hbbbb0000, 32'haaaa0000}, 32'h1c000004, 0, 0);
        chk("mis_cnt", 32'(iq_count), 32'd1);
        chk("mis_pc", pc_f, 32'h1c000004);
        chk("mis_inst", inst_f, 32'hbbbb0000);
        cyc(0, 0, 64'h0, 32'h0, 0, 0);

        // Stall while four beats fill the queue
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        chk("st_fa_out2", 32'(fetch_ahead), 32'd0);
        cyc(1, 1, {32'h11, 32'h10}, 32'h00000100, 0, 1);
        cyc(1, 1, {32'h13, 32'h12}, 32'h00000108, 0, 1);
        cyc(0, 1, {32'h15, 32'h14}, 32'h00000110, 0, 1);
        cyc(0, 1, {32'h17, 32'h16}, 32'h00000118, 0, 1);
        chk("st_cnt", 32'(iq_count), 32'd8);
        chk("st_head_pc", pc_f, 32'h00000100);
        chk("st_head_inst", inst_f, 32'h10);
        chk("st_fa_full", 32'(fetch_ahead), 32'd0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 64'h0, 32'h0, 0, 0);

        // Overflow: fill to 7 then push a full beat with no dequeue
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 64'h0, 32'h0, 0, 1);
            cyc(0, 1, {32'(i*2+1), 32'(i*2)}, 32'h00002000 + 32'(i*8), 0, 1);
        end
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(0, 1, {32'h77, 32'h66}, 32'h00002034, 0, 1);
        chk("ov_cnt7", 32'(iq_count), 32'd7);
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(0, 1, {32'h99, 32'h88}, 32'h00002040, 0, 1);
        chk("ov_cnt_hold", 32'(iq_count), 32'd7);
        chk("ov_flag", 32'(ibuf_ovf_err), 32'd1);

        // Flush with two beats in flight
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(0, 0, 64'h0, 32'h0, 1, 1);
        chk("fl_cnt", 32'(iq_count), 32'd0);
        chk("fl_ovf_sticky", 32'(ibuf_ovf_err), 32'd1);
        cyc(0, 1, {32'hdead0001, 32'hdead0000}, 32'h00003000, 0, 1);
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(0, 1, {32'hdead0003, 32'hdead0002}, 32'h00003008, 0, 1);
        chk("fl_drop2", 32'(iq_count), 32'd0);
        cyc(0, 1, {32'hcafe0001, 32'hcafe0000}, 32'h00004000, 0, 1);
        chk("fl_keep3", 32'(iq_count), 32'd2);
        chk("fl_keep3_pc", pc_f, 32'h00004000);
        for (int i = 0; i < 2; i++) cyc(0, 0, 64'h0, 32'h0, 0, 0);

        // Reset mid-operation with count 5 and one beat outstanding
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 64'h0, 32'h0, 0, 1);
            cyc(0, 1, {32'(i+100), 32'(i+200)}, 32'h00005000 + 32'(i*8), 0, 1);
        end
        cyc(1, 0, 64'h0, 32'h0, 0, 1);
        cyc(1, 1, {32'h5, 32'h4}, 32'h00005014, 0, 1);
        chk("mr_cnt5", 32'(iq_count), 32'd5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mr_count", 32'(iq_count), 32'd0);
        chk("mr_valid", 32'(inst_valid_f), 32'd0);
        chk("mr_ne", 32'(iq_not_empty), 32'd0);
        chk("mr_ovf", 32'(ibuf_ovf_err), 32'd0);
        chk("mr_fa", 32'(fetch_ahead), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        ack = 0; dvalid = 0; flush = 0; stall = 0;
        cyc(0, 1, {32'h0000beef, 32'h0000feed}, 32'h00006000, 0, 1);
        chk("mr_late_cnt", 32'(iq_count), 32'd2);
        chk("mr_late_inst", inst_f, 32'h0000feed);
        for (int i = 0; i < 2; i++) cyc(0, 0, 64'h0, 32'h0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          ra, rv, rf, rs;
            logic [31:0] rp;
            ra = ($urandom_range(0, 9) == 0) || (model_fa() && $urandom_range(0, 1) == 1);
            rv = (m_out > 0) && ($urandom_range(0, 1) == 1);
            rf = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 2) == 0);
            rp = $urandom & 32'hfffffffc;
            cyc(ra, rv, {$urandom, $urandom}, rp, rf, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu7_ifu_ibuf.md
CPU7_IFU_IBUF -- requirements
Module: cpu7_ifu_ibuf

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of 32-bit instruction entries; power of 2, and DEPTH >= 2*FETCH_W.
REQ-002 SHALL have parameter FETCH_W, default 2: instructions per fetch beat; legal values 1, 2, 4.
REQ-003 SHALL have parameter MAX_OUT, default 2: maximum outstanding fetch requests, range 1..4.
REQ-004 SHALL have the following ports:
- clk, input, 1: sole clock; all state is rising-edge.
- reset, input, 1: asynchronous, active-high.
- ifu_icu_ack_ic1, input, 1: fetch request accepted by the ICU; reserves one beat.
- icu_ifu_data_ic2, input, 32*FETCH_W: fetch beat; slot i occupies bits [32i+31:32i].
- icu_ifu_data_valid_ic2, input, 1: beat valid this cycle.
- fetch_pc_ic2, input, 32: PC of the beat.
- flush_iq, input, 1: discard queue contents and in-flight beats.
- exu_ifu_stall_req, input, 1: hold the head entry.
- inst_f, output, 32: head instruction.
- pc_f, output, 32: head PC.
- inst_valid_f, output, 1: head is presented and consumed this cycle.
- iq_not_empty, output, 1: count != 0.
- iq_count, output, log2(DEPTH)+1: occupied entries.
- fetch_ahead, output, 1: a new request may be issued.
- ibuf_ovf_err, output, 1: sticky overflow flag.

Function
REQ-005 SHALL implement a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
REQ-006 SHALL compute beat offset off = fetch_pc_ic2[log2(FETCH_W)+1:2] (off = 0 when FETCH_W = 1), and n = FETCH_W - off.
REQ-007 On an accepted beat, SHALL write slots off..FETCH_W-1 in ascending order at tail..tail+n-1 (wrapping), then advance tail by n.
REQ-008 SHALL store each entry's PC as {fetch_pc_ic2[31:log2(FETCH_W)+2], slot, 2'b00}.
REQ-009 Enqueue latency SHALL be 1 cycle: an entry written at edge k is first visible on inst_f/pc_f after edge k; there is no empty-bypass.
REQ-010 inst_f and pc_f SHALL be driven combinationally from the head entry; their value is don't-care when empty.
REQ-011 inst_valid_f SHALL equal iq_not_empty & ~exu_ifu_stall_req & ~flush_iq.
REQ-012 When inst_valid_f = 1, the head SHALL advance by 1 at the next edge (dequeue).
REQ-013 Simultaneous enqueue and dequeue SHALL be legal; next count = count + n*enq - deq.
REQ-014 SHALL keep an outstanding counter (width log2(MAX_OUT)+1):
- +1 on ifu_icu_ack_ic1;
- -1 on icu_ifu_data_valid_ic2;
- both in the same cycle: unchanged.
REQ-015 fetch_ahead SHALL be 1 iff (DEPTH - count - FETCH_W*outstanding) >= FETCH_W and outstanding < MAX_OUT, evaluated combinationally from current registers.
REQ-016 An ack arriving while fetch_ahead = 0 SHALL still be counted, saturating at MAX_OUT.
REQ-017 Overflow: a beat with n > DEPTH - count + deq SHALL be dropped entirely and SHALL set ibuf_ovf_err, which is cleared only by reset.
REQ-018 flush_iq SHALL take priority over everything:
- next count = 0 and head = tail = 0;
- any same-cycle enqueue is discarded;
- dequeue is suppressed.
REQ-019 On flush_iq, SHALL load drop counter = outstanding - (icu_ifu_data_valid_ic2 ? 1 : 0) + (ifu_icu_ack_ic1 ? 1 : 0).
REQ-020 While the drop counter is nonzero, each arriving beat SHALL be discarded, decrement the drop counter, and decrement outstanding as normal.
REQ-021 A flush asserted while the drop counter is nonzero SHALL reload it per REQ-019.
REQ-022 exu_ifu_stall_req SHALL not block enqueue, acks, or the drop logic.

Reset
REQ-023 Reset (asynchronous, active-high) SHALL clear head, tail, count, outstanding, drop counter, and ibuf_ovf_err to 0, at any time including mid-beat.
REQ-024 Output values during and after reset SHALL be:
- inst_valid_f = 0, iq_not_empty = 0, iq_count = 0, ibuf_ovf_err = 0;
- fetch_ahead = 1;
- entry storage is not reset.

Verification (DEPTH=8, FETCH_W=2, MAX_OUT=2)
REQ-025 Aligned beat: ack, then beat at pc 0x1c000000 with data {0x00000002, 0x00000001} -> next cycle inst_f = 0x00000001, pc_f = 0x1c000000, iq_count = 2; next cycle inst_f = 0x00000002, pc_f = 0x1c000004, iq_count = 1; then iq_count = 0.
REQ-026 Misaligned beat: beat at pc 0x1c000004 -> only the upper word is enqueued, iq_count = 1, pc_f = 0x1c000004.
REQ-027 Stall: hold exu_ifu_stall_req while issuing 4 beats (2 acks outstanding max) -> head unchanged, iq_count reaches 8, fetch_ahead = 0 once count + 2*outstanding > 6.
REQ-028 Flush with outstanding = 2 -> iq_count = 0 next cycle; the next 2 beats are dropped; the 3rd (post-flush ack) is enqueued.
REQ-029 Overflow: iq_count = 7, beat with n = 2, no dequeue -> beat dropped, iq_count stays 7, ibuf_ovf_err = 1 until reset.
REQ-030 Reset mid-operation: assert reset with iq_count = 5 and outstanding = 1 -> all outputs go to reset values immediately (asynchronously); a late beat after reset is enqueued normally.
